// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the HSST TX FIFO burst read controller.
package fifo_burst_pkg;

  localparam int         DATA_W        = 16;
  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
  localparam logic [7:0] TRL_MAGIC_DEF = 8'h5A;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    TRL     = 3'd3,
    CSUM    = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_burst_skid.sv
// Two-entry skid buffer with fall-through when empty, so an arriving word can be
// taken in the cycle it arrives and a stalled word is held in registers.
module fifo_burst_skid
  import fifo_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              stored_s, push_s, pop_s;

  // Stored entries always take priority over the bypass path to keep ordering.
  always_comb begin
    stored_s  = (cnt_q != 2'd0);
    out_valid = stored_s || in_valid;
    if (stored_s) begin
      out_data = mem_q[rd_ptr_q];
    end else if (in_valid) begin
      out_data = in_data;
    end else begin
      out_data = '0;
    end
    push_s   = in_valid && (stored_s || !out_ready);
    pop_s    = stored_s && out_ready;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = !wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = !rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler: drains the TX FIFO and frames words as header/payload/trailer.
// Define FIFO_BURST_CSUM_EN to append a 16-bit payload checksum word after the trailer.
module fifo_burst_rd_ctrl
  import fifo_burst_pkg::*;
#(
  parameter int         BURST_LEN = 64,
  parameter int         TIMEOUT   = 1024,
  parameter int         GAP_MAX   = 8,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter logic [7:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              fifo_almost_empty,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy
);

  localparam int              TW          = $clog2(TIMEOUT) + 1;
  localparam int              GW          = $clog2(GAP_MAX + 1);
  localparam logic [7:0]      BURST_LEN_W = 8'(BURST_LEN);
  localparam logic [TW-1:0]   TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]   GAP_LAST    = GW'(GAP_MAX);

  state_e            state_q, state_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        issued_q, issued_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              inflight_q;
`ifdef FIFO_BURST_CSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic              rd_en_s, accept_s, gap_exit_s;
  logic              skid_valid_s, skid_ready_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [1:0]        skid_cnt_s;
  logic [DATA_W-1:0] tx_data_s;
  logic              tx_valid_s, tx_sop_s, tx_eop_s;

  fifo_burst_skid u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .in_valid  (inflight_q),
    .in_data   (fifo_rd_data),
    .out_valid (skid_valid_s),
    .out_ready (skid_ready_s),
    .out_data  (skid_data_s),
    .count     (skid_cnt_s)
  );

  // Read gating: at most two words outstanding between the FIFO and the skid buffer.
  always_comb begin
    skid_ready_s = (state_q == PAYLOAD) && tx_ready;
    accept_s     = skid_valid_s && skid_ready_s;
    gap_exit_s   = (gap_q == GAP_LAST) && (skid_cnt_s == 2'd0) && !inflight_q &&
                   (len_q != 8'd0);
    rd_en_s      = !rd_rst && (state_q == PAYLOAD) && !fifo_rd_empty &&
                   (issued_q < BURST_LEN_W) &&
                   (({1'b0, skid_cnt_s} + {2'b00, inflight_q}) < 3'd2) && !gap_exit_s;
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    len_d      = len_q;
    issued_d   = issued_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    tx_data_s  = '0;
    tx_valid_s = 1'b0;
    tx_sop_s   = 1'b0;
    tx_eop_s   = 1'b0;
`ifdef FIFO_BURST_CSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        issued_d = 8'd0;
        gap_d    = '0;
        len_d    = 8'd0;
        if (!fifo_rd_empty && fifo_almost_empty) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = '0;
        end
        // Either enough data for a full-rate burst, or a trickle that has waited long enough.
        if (!fifo_rd_empty && (!fifo_almost_empty || (timer_q == TIMER_LAST))) begin
          state_d = HDR;
          timer_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        tx_data_s  = {HDR_MAGIC, seq_q};
        tx_valid_s = 1'b1;
        tx_sop_s   = 1'b1;
        gap_d      = '0;
`ifdef FIFO_BURST_CSUM_EN
        sum_d      = '0;
`endif
        if (tx_ready) begin
          state_d = PAYLOAD;
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        tx_data_s  = skid_data_s;
        tx_valid_s = skid_valid_s;
        if (rd_en_s) begin
          issued_d = issued_q + 8'd1;
        end else begin
          issued_d = issued_q;
        end
        if (fifo_rd_empty) begin
          gap_d = (gap_q == GAP_LAST) ? gap_q : (gap_q + GW'(1));
        end else begin
          gap_d = '0;
        end
        if (accept_s) begin
          len_d = len_q + 8'd1;
`ifdef FIFO_BURST_CSUM_EN
          sum_d = sum_q + skid_data_s;
`endif
        end else begin
          len_d = len_q;
        end
        if ((accept_s && ((len_q + 8'd1) == BURST_LEN_W)) || gap_exit_s) begin
          state_d = TRL;
        end else begin
          state_d = PAYLOAD;
        end
      end
      TRL: begin
        tx_data_s  = {TRL_MAGIC, len_q};
        tx_valid_s = 1'b1;
`ifdef FIFO_BURST_CSUM_EN
        tx_eop_s   = 1'b0;
        if (tx_ready) begin
          state_d = CSUM;
        end else begin
          state_d = TRL;
        end
`else
        tx_eop_s   = 1'b1;
        if (tx_ready) begin
          state_d = IDLE;
          seq_d   = seq_q + 8'd1;
          len_d   = 8'd0;
        end else begin
          state_d = TRL;
        end
`endif
      end
`ifdef FIFO_BURST_CSUM_EN
      CSUM: begin
        tx_data_s  = sum_q;
        tx_valid_s = 1'b1;
        tx_eop_s   = 1'b1;
        if (tx_ready) begin
          state_d = IDLE;
          seq_d   = seq_q + 8'd1;
          len_d   = 8'd0;
        end else begin
          state_d = CSUM;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset also drops any word still in flight from the FIFO.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      seq_q      <= 8'd0;
      len_q      <= 8'd0;
      issued_q   <= 8'd0;
      timer_q    <= '0;
      gap_q      <= '0;
      inflight_q <= 1'b0;
`ifdef FIFO_BURST_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      inflight_q <= rd_en_s;
`ifdef FIFO_BURST_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign tx_data    = tx_data_s;
  assign tx_valid   = tx_valid_s;
  assign tx_sop     = tx_sop_s;
  assign tx_eop     = tx_eop_s;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Scoreboard bench for fifo_burst_rd_ctrl: a queue-based FIFO model feeds the DUT and a
// frame-level reference model checks every accepted word. Honours FIFO_BURST_CSUM_EN.
module tb_fifo_burst_rd_ctrl;

  localparam int BURST_LEN = 64;
  localparam int TIMEOUT   = 1024;
`ifdef FIFO_BURST_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
  localparam bit TRL_EOP = 1'b0;
`else
  localparam bit CSUM_ON = 1'b0;
  localparam bit TRL_EOP = 1'b1;
`endif

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'h0000;
  logic        fifo_rd_empty = 1'b1;
  logic        fifo_almost_empty = 1'b1;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic        busy;

  fifo_burst_rd_ctrl dut (
    .rd_clk            (rd_clk),
    .rd_rst            (rd_rst),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_empty     (fifo_rd_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_sop            (tx_sop),
    .tx_eop            (tx_eop),
    .busy              (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] fq[$];
  logic [15:0] wr_q[$];
  logic [15:0] exp_pl[$];
  int          exp_len[$];
  bit          fifo_flush = 1'b0;
  bit          rand_ready = 1'b0;
  bit          mon_en     = 1'b0;
  int          phase      = 0;
  int          m_len      = 0;
  logic [7:0]  m_seq      = 8'd0;
  logic [15:0] m_sum      = 16'd0;
  bit          stall_prev = 1'b0;
  logic [15:0] prev_data  = 16'd0;
  logic [31:0] got_w, exp_w;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [15:0] w);
    wr_q.push_back(w);
    exp_pl.push_back(w);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 6000 && !(exp_pl.size() == 0 && phase == 0 && !busy && fifo_rd_empty &&
                         wr_q.size() == 0)) begin
      @(negedge rd_clk);
      n++;
    end
    chk({name, "_drain"}, n < 6000, n, 6000);
    chk({name, "_frames"}, exp_len.size() == 0, exp_len.size(), 0);
  endtask

  // FIFO model: one-cycle read latency, writes become visible on the next edge
  always @(posedge rd_clk) begin
    if (fifo_flush) begin
      fq.delete();
      wr_q.delete();
    end else begin
      if (fifo_rd_en) begin
        chk("rd_not_empty", fq.size() != 0, fq.size(), 1);
        if (fq.size() != 0) fifo_rd_data <= fq.pop_front();
      end
      while (wr_q.size() != 0) fq.push_back(wr_q.pop_front());
    end
    fifo_rd_empty     <= (fq.size() == 0);
    fifo_almost_empty <= (fq.size() <= 4);
  end

  // Downstream ready: always high or ~50% random
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge rd_clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: frame-level reference model applied to every accepted word
  always @(negedge rd_clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("stall_valid", tx_valid == 1'b1, {31'd0, tx_valid}, 1);
        chk("stall_data", tx_data == prev_data, tx_data, prev_data);
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (fifo_rd_en) chk("rd_in_payload", busy && !tx_sop, {busy, tx_sop}, 2);
      if (tx_valid && tx_ready) begin
        got_w = {14'd0, tx_sop, tx_eop, tx_data};
        if (phase == 0) begin
          exp_w = {14'd0, 1'b1, 1'b0, 8'hA5, m_seq};
          chk("header", got_w == exp_w, got_w, exp_w);
          phase = 1;
          m_len = 0;
          m_sum = 16'd0;
        end else if (phase == 1 && tx_data[15:8] != 8'h5A) begin
          if (exp_pl.size() != 0) exp_w = {16'd0, exp_pl.pop_front()};
          else exp_w = 32'hFFFF_FFFF;
          chk("payload", got_w == exp_w, got_w, exp_w);
          m_len++;
          m_sum = m_sum + tx_data;
          chk("payload_len_max", m_len <= BURST_LEN, m_len, BURST_LEN);
        end else if (phase == 1) begin
          exp_w = {14'd0, 1'b0, TRL_EOP, 8'h5A, 8'(m_len)};
          chk("trailer", got_w == exp_w, got_w, exp_w);
          chk("trailer_nonempty", m_len >= 1, m_len, 1);
          if (exp_len.size() != 0) begin
            int l;
            l = exp_len.pop_front();
            chk("frame_len", m_len == l, m_len, l);
          end
          if (CSUM_ON) begin
            phase = 2;
          end else begin
            phase = 0;
            m_seq = m_seq + 8'd1;
          end
        end else begin
          exp_w = {14'd0, 1'b0, 1'b1, m_sum};
          chk("checksum", got_w == exp_w, got_w, exp_w);
          phase = 0;
          m_seq = m_seq + 8'd1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    bit rd_seen;
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("reset_outputs", {tx_valid, tx_sop, tx_eop, busy, fifo_rd_en, tx_data} == 21'd0,
        {tx_valid, tx_sop, tx_eop, busy, fifo_rd_en, tx_data}, 0);
    mon_en = 1'b1;

    // 1) 100 preloaded words: a full 64-word frame, then a 36-word gap-closed frame
    exp_len.push_back(64);
    exp_len.push_back(36);
    for (int i = 0; i < 100; i++) put_word(16'(i));
    wait_idle("preload");

    // 2) 3 words, almost-empty throughout: start only after the timeout
    exp_len.push_back(3);
    for (int i = 0; i < 3; i++) put_word(16'h1230 + 16'(i));
    n = 0;
    while (fifo_rd_empty && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    n = 0;
    rd_seen = 1'b0;
    while (!tx_sop && n < 3000) begin
      if (fifo_rd_en) rd_seen = 1'b1;
      @(negedge rd_clk);
      n++;
    end
    chk("timeout_hdr_cycle", n == TIMEOUT, n, TIMEOUT);
    chk("timeout_no_rd", !rd_seen, {31'd0, rd_seen}, 0);
    wait_idle("timeout");

    // 4) short gap (below GAP_MAX) mid-frame must not close the frame
    exp_len.push_back(20);
    for (int i = 0; i < 10; i++) put_word(16'h0400 + 16'(i));
    n = 0;
    while (!(fifo_rd_empty && phase == 1 && m_len > 0) && n < 200) begin
      @(negedge rd_clk);
      n++;
    end
    chk("gap_reached_empty", n < 200, n, 200);
    repeat (3) @(negedge rd_clk);
    for (int i = 10; i < 20; i++) put_word(16'h0400 + 16'(i));
    wait_idle("short_gap");

    // 3) random backpressure with 500 random words streamed in
    rand_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20000 && cnt < 500; c++) begin
      @(posedge rd_clk);
      #1;
      if ((fq.size() + wr_q.size()) < 250 && $urandom_range(0, 3) != 0) begin
        put_word(16'($urandom_range(0, 16'h4FFF)));
        cnt++;
      end
    end
    chk("stream_issued", cnt == 500, cnt, 500);
    wait_idle("random");
    rand_ready = 1'b0;

    // 5) reset in the middle of a payload
    for (int i = 0; i < 40; i++) put_word(16'h0700 + 16'(i));
    n = 0;
    while (!(phase == 1 && m_len >= 5) && n < 500) begin
      @(negedge rd_clk);
      n++;
    end
    chk("reset_mid_payload_reached", n < 500, n, 500);
    @(posedge rd_clk);
    #1;
    rd_rst     = 1'b1;
    fifo_flush = 1'b1;
    mon_en     = 1'b0;
    exp_pl.delete();
    exp_len.delete();
    @(posedge rd_clk);
    #1;
    rd_rst     = 1'b0;
    fifo_flush = 1'b0;
    @(negedge rd_clk);
    chk("midreset_outputs", {tx_valid, tx_sop, tx_eop, busy, fifo_rd_en, tx_data} == 21'd0,
        {tx_valid, tx_sop, tx_eop, busy, fifo_rd_en, tx_data}, 0);
    m_seq      = 8'd0;
    phase      = 0;
    m_len      = 0;
    stall_prev = 1'b0;
    mon_en     = 1'b1;
    exp_len.push_back(10);
    for (int i = 0; i < 10; i++) put_word(16'h0900 + 16'(i));
    wait_idle("after_reset");

`ifdef FIFO_BURST_CSUM_EN
    // 6) checksum wraps modulo 2^16
    exp_len.push_back(3);
    put_word(16'h0001);
    put_word(16'hFFFF);
    put_word(16'h0002);
    wait_idle("csum");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
